// File: rtl/kpn_channel_monitor.sv
// rtl/kpn_channel_monitor.sv - KPN output channel monitor with FWFT token capture buffer
// Optional feature macro: MONITOR_CHANGE_DETECT_EN (tokens also generated on data change while ch_valid is low)
module kpn_channel_monitor #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int LOG_DEPTH   = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [CH_W-1:0]              rd_ch,
  output logic [LOG_DEPTH:0]           fifo_count,
  output logic [31:0]                  total_tokens,
  output logic [15:0]                  drop_count,
  output logic                         overflow,
  output logic [NUM_CH-1:0]            stall_flags
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam int ENT_W = CH_W + DATA_WIDTH;

  logic [NUM_CH-1:0]     tok;
  logic                  cand_any;
  logic [CH_W-1:0]       cand_idx;
  logic [DATA_WIDTH-1:0] cand_data;
  logic [4:0]            n_tok;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic [4:0]            drops_now;
  logic [16:0]           drop_sum;

  logic [ENT_W-1:0]      mem [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr;
  logic [LOG_DEPTH-1:0]  rd_ptr;
  logic [15:0]           idle [NUM_CH];

`ifdef MONITOR_CHANGE_DETECT_EN
  logic [NUM_CH*DATA_WIDTH-1:0] last_data;

  // History of every channel word, used to spot changes on strobe-less outputs
  always_ff @(posedge clk) begin
    if (reset) last_data <= '0;
    else       last_data <= ch_data;
  end

  // A token is a strobe or a change of the word since the previous cycle
  always_comb begin
    tok = ch_valid;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_data[k*DATA_WIDTH +: DATA_WIDTH] != last_data[k*DATA_WIDTH +: DATA_WIDTH])
        tok[k] = 1'b1;
    end
  end
`else
  // Tokens come from the strobes only
  always_comb begin
    tok = ch_valid;
  end
`endif

  // Lowest-index token wins; count all tokens so the losers can be charged as drops
  always_comb begin
    cand_any = 1'b0;
    cand_idx = '0;
    n_tok    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (tok[k]) begin
        cand_any = 1'b1;
        cand_idx = CH_W'(k);
      end
      n_tok = n_tok + 5'(tok[k]);
    end
    cand_data = ch_data[cand_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Push/pop decisions and this cycle's drop total (every token that is not pushed is lost)
  always_comb begin
    full      = (fifo_count == DEPTH[LOG_DEPTH:0]);
    pop       = rd_en && (fifo_count != '0);
    push      = cand_any && (!full || pop);
    drops_now = n_tok - 5'(push);
    drop_sum  = {1'b0, drop_count} + 17'(drops_now);
  end

  // Capture buffer storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {cand_idx, cand_data};
  end

  // Pointers, occupancy and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      total_tokens <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (push) total_tokens <= total_tokens + 32'd1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (drops_now != '0) overflow <= 1'b1;
    end
  end

  // Per-channel idle counters: clear on any token, otherwise count up to the stall limit
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (reset || tok[k])                idle[k] <= '0;
      else if (idle[k] != 16'(STALL_LIMIT)) idle[k] <= idle[k] + 16'd1;
    end
  end

  // Stall flag is a pure decode of the saturated idle counter
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) stall_flags[k] = (idle[k] == 16'(STALL_LIMIT));
  end

  // First-word-fall-through head
  always_comb begin
    rd_valid = (fifo_count != '0);
    {rd_ch, rd_data} = mem[rd_ptr];
  end

endmodule

// File: tb/tb_kpn_channel_monitor.sv
// tb/tb_kpn_channel_monitor.sv - randomized and directed bench for kpn_channel_monitor against a queue model
module tb_kpn_channel_monitor;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int LD = 4;
  localparam int SL = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NC*DW-1:0] ch_data = '0;
  logic [NC-1:0]  ch_valid = '0;
  logic           rd_en = 1'b0;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic [CW-1:0]  rd_ch;
  logic [LD:0]    fifo_count;
  logic [31:0]    total_tokens;
  logic [15:0]    drop_count;
  logic           overflow;
  logic [NC-1:0]  stall_flags;

  always #5 clk = ~clk;

  kpn_channel_monitor #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .CH_W(CW), .LOG_DEPTH(LD), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ch(rd_ch), .fifo_count(fifo_count),
    .total_tokens(total_tokens), .drop_count(drop_count), .overflow(overflow),
    .stall_flags(stall_flags)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: a queue of {channel, word} plus plain counters
  logic [CW+DW-1:0] m_q[$];
  logic [31:0]      m_total;
  int               m_drop;
  logic             m_ovf;
  int               m_idle[NC];
  logic [NC*DW-1:0] m_last;

  task automatic step(input logic [NC-1:0] v, input logic [NC*DW-1:0] d,
                      input logic re, input logic rst);
    logic [NC-1:0] t;
    int ntok;
    int lost;
    int win;
    @(negedge clk);
    ch_valid = v;
    ch_data  = d;
    rd_en    = re;
    reset    = rst;
    if (rst) begin
      m_q.delete();
      m_total = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      m_last  = '0;
      for (int k = 0; k < NC; k++) m_idle[k] = 0;
    end else begin
      t = v;
`ifdef MONITOR_CHANGE_DETECT_EN
      for (int k = 0; k < NC; k++)
        if (d[k*DW +: DW] != m_last[k*DW +: DW]) t[k] = 1'b1;
      m_last = d;
`endif
      ntok = $countones(t);
      lost = 0;
      if (re && m_q.size() > 0) void'(m_q.pop_front());
      if (ntok > 0) begin
        win = 0;
        for (int k = NC - 1; k >= 0; k--) if (t[k]) win = k;
        if (m_q.size() < 2 ** LD) begin
          m_q.push_back({win[CW-1:0], d[win*DW +: DW]});
          m_total = m_total + 1;
        end else begin
          lost = 1;
        end
        lost = lost + ntok - 1;
      end
      m_drop = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
      if (lost > 0) m_ovf = 1'b1;
      for (int k = 0; k < NC; k++)
        m_idle[k] = t[k] ? 0 : ((m_idle[k] < SL) ? m_idle[k] + 1 : SL);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step('0, ch_data, 1'b0, 1'b0);
  endtask

  function automatic logic [76:0] exp_vec();
    logic [CW+DW-1:0] head;
    logic [NC-1:0] st;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    for (int k = 0; k < NC; k++) st[k] = (m_idle[k] == SL);
    return {m_q.size() > 0, head[DW-1:0], head[CW+DW-1:DW], 5'(m_q.size()),
            m_total, 16'(m_drop), m_ovf, st};
  endfunction

  function automatic logic [76:0] obs_vec();
    return {rd_valid, rd_valid ? rd_data : 16'h0, rd_valid ? rd_ch : 2'b0, fifo_count,
            total_tokens, drop_count, overflow, stall_flags};
  endfunction

  task automatic test_reset();
    step('0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({rd_valid, fifo_count, total_tokens, drop_count, overflow, stall_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b cnt=%0d tot=%0d drp=%0d ovf=%b st=%b, expected all zero",
               rd_valid, fifo_count, total_tokens, drop_count, overflow, stall_flags);
    end
  endtask

  task automatic test_single();
    step(4'b0001, {48'h0, 16'h00A5}, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_ch, fifo_count, total_tokens} !== {1'b1, 16'h00A5, 2'd0, 5'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL single_token: got v=%b d=%h ch=%0d cnt=%0d tot=%0d, expected v=1 d=00a5 ch=0 cnt=1 tot=1",
               rd_valid, rd_data, rd_ch, fifo_count, total_tokens);
    end
  endtask

  task automatic test_collision();
    step(4'b1010, {16'h3333, 16'h0000, 16'h1111, 16'h00A5}, 1'b0, 1'b0);
    n_checks++;
    if ({drop_count, overflow, fifo_count} !== {16'd1, 1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL collision_stats: got drp=%0d ovf=%b cnt=%0d, expected drp=1 ovf=1 cnt=2",
               drop_count, overflow, fifo_count);
    end
    step('0, ch_data, 1'b1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_ch} !== {1'b1, 16'h1111, 2'd1}) begin
      n_fail++;
      $display("FAIL collision_entry: got v=%b d=%h ch=%0d, expected v=1 d=1111 ch=1",
               rd_valid, rd_data, rd_ch);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL collision_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0100, 64'(i) << 32, 1'b0, 1'b0);
    n_checks++;
    if ({fifo_count, drop_count, total_tokens, overflow} !== {5'd16, 16'd4, 32'd16, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_stats: got cnt=%0d drp=%0d tot=%0d ovf=%b, expected cnt=16 drp=4 tot=16 ovf=1",
               fifo_count, drop_count, total_tokens, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({rd_valid, rd_data, rd_ch} !== {1'b1, 16'(i), 2'd2}) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got v=%b d=%h ch=%0d, expected v=1 d=%h ch=2",
                 i, rd_valid, rd_data, rd_ch, 16'(i));
      end
      step('0, ch_data, 1'b1, 1'b0);
    end
    n_checks++;
    if ({rd_valid, fifo_count} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL drain_empty: got v=%b cnt=%0d, expected v=0 cnt=0", rd_valid, fifo_count);
    end
    step('0, ch_data, 1'b1, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || fifo_count !== 5'd0 || total_tokens !== 32'd16) begin
      n_fail++;
      $display("FAIL pop_when_empty: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_pushpop();
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(4'b0001, 64'(100 + i), 1'b0, 1'b0);
    step(4'b0001, 64'hBEEF, 1'b1, 1'b0);
    n_checks++;
    if ({fifo_count, drop_count, overflow, rd_data} !== {5'd16, 16'd0, 1'b0, 16'd101}) begin
      n_fail++;
      $display("FAIL full_pushpop: got cnt=%0d drp=%0d ovf=%b head=%0d, expected cnt=16 drp=0 ovf=0 head=101",
               fifo_count, drop_count, overflow, rd_data);
    end
    for (int i = 0; i < 15; i++) step('0, ch_data, 1'b1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_ch, fifo_count} !== {1'b1, 16'hBEEF, 2'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL wrap_tail: got v=%b d=%h ch=%0d cnt=%0d, expected v=1 d=beef ch=0 cnt=1",
               rd_valid, rd_data, rd_ch, fifo_count);
    end
  endtask

  task automatic test_stall();
    step('0, '0, 1'b0, 1'b1);
    idle_cycles(63);
    n_checks++;
    if (stall_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL stall_early: got %b expected 0000", stall_flags);
    end
    idle_cycles(1);
    n_checks++;
    if (stall_flags !== 4'b1111) begin
      n_fail++;
      $display("FAIL stall_set: got %b expected 1111", stall_flags);
    end
    step(4'b1000, {16'h0005, 48'h0}, 1'b0, 1'b0);
    n_checks++;
    if (stall_flags !== 4'b0111) begin
      n_fail++;
      $display("FAIL stall_clear: got %b expected 0111", stall_flags);
    end
  endtask

  task automatic test_reset_mid();
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0011, {32'h0, 16'(i + 1), 16'(i + 1)}, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || fifo_count !== 5'd5) begin
      n_fail++;
      $display("FAIL pre_reset: got %h expected %h", obs_vec(), exp_vec());
    end
    step(4'b1111, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
    n_checks++;
    if ({rd_valid, fifo_count, total_tokens, drop_count, overflow, stall_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b cnt=%0d tot=%0d drp=%0d ovf=%b st=%b, expected all zero",
               rd_valid, fifo_count, total_tokens, drop_count, overflow, stall_flags);
    end
  endtask

`ifdef MONITOR_CHANGE_DETECT_EN
  task automatic test_change_detect();
    step('0, '0, 1'b0, 1'b1);
    step('0, 64'h0007, 1'b0, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_ch, fifo_count} !== {1'b1, 16'h0007, 2'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL change_detect: got v=%b d=%h ch=%0d cnt=%0d, expected v=1 d=0007 ch=0 cnt=1",
               rd_valid, rd_data, rd_ch, fifo_count);
    end
  endtask
`endif

  task automatic test_random();
    logic [NC-1:0] v;
    logic [NC*DW-1:0] d;
    int errs;
    errs = 0;
    step('0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = 4'(1 << $urandom_range(0, NC - 1));
        default: v = 4'($urandom);
      endcase
      d = ch_data;
      for (int k = 0; k < NC; k++) if (v[k]) d[k*DW +: DW] = 16'($urandom);
      step(v, d, ($urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 30 : 70)),
           ($urandom_range(0, 399) == 0));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_model cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_fill_drain();
    test_full_pushpop();
    test_stall();
    test_reset_mid();
`ifdef MONITOR_CHANGE_DETECT_EN
    test_change_detect();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
